gate_pair_apply: RTL and testbench
==================================

Name: gate_pair_apply

Overview:
- Applies one 2x2 complex gate matrix U to one complex amplitude pair (a0, a1): out0 = u00*a0 + u01*a1, out1 = u10*a0 + u11*a1.
- Sits directly upstream of the fixed-point multiplier. It instantiates exactly one fixmul and time-multiplexes all 16 real products through it, one per cycle.
- It feeds fixmul's operands, accumulates its products, and saturates the results.
- Used by the state-vector update path between the amplitude memory reader and writer.

Parameters:
- W, 19: real/imag component width. Signed fixed point: sign bit plus W-1 fraction bits; value range (-1, 1). fixmul is instantiated with IN_BITS = OUT_BITS = W.
- ACC_W, W+2: accumulator width. Sized to hold the sum of 4 products without overflow.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  U and amplitude pair presented.
- in_ready  out  1  block can accept; high only in IDLE.
- u_mat  in  8*W  packed {u11_im,u11_re,u10_im,u10_re,u01_im,u01_re,u00_im,u00_re}; u00_re at LSBs.
- amp_in  in  4*W  packed {a1_im,a1_re,a0_im,a0_re}; a0_re at LSBs.
- out_valid  out  1  amp_out valid; held until accepted.
- out_ready  in  1  downstream accepts.
- amp_out  out  4*W  packed {o1_im,o1_re,o0_im,o0_re}, same packing as amp_in.
- sat  out  1  one or more of the 4 results saturated; qualified by out_valid.

Behaviour:
- Reset: the async assert of reset_n forces IDLE and clears all registers. in_ready=1 (combinational from state), out_valid=0, amp_out=0, sat=0, counter=0, accumulators=0. Reset mid-operation abandons the transaction; no partial output appears.
- Capture: on an edge where in_valid & in_ready, register u_mat and amp_in and go to MUL with k=0.
  - Every captured component equal to -2^(W-1) is clamped to -(2^(W-1)-1), because fixmul cannot handle the most negative value.
  - in_valid while not IDLE is ignored; inputs need not be held after capture.
- FSM: IDLE -> MUL -> SAT -> DONE -> IDLE.
- MUL: 16 cycles, k = 0..15. fixmul is driven combinationally from registered operands selected by k.
  - k[3] = row r, k[2] = col c, k[1:0] = term t. Operands are u_rc and a_c.
  - t=0: u.re*a.re, added to acc_re[r].
  - t=1: u.im*a.im, subtracted from acc_re[r].
  - t=2: u.re*a.im, added to acc_im[r].
  - t=3: u.im*a.re, added to acc_im[r].
  - Products are sign-extended to ACC_W before add/sub. Accumulators are cleared on capture.
  - At the edge consuming k=15, go to SAT.
- SAT: one edge. Each accumulator is clamped to the symmetric range [-(2^(W-1)-1), 2^(W-1)-1] and registered into amp_out. sat = OR of the 4 clamp events. out_valid set; go to DONE.
- Latency: capture edge E0; MUL edges E1..E16; SAT edge E17; out_valid is high from E17. Minimum initiation interval is 19 cycles (DONE->IDLE, then the next capture).
- DONE: amp_out, sat and out_valid are stable while out_ready=0. On an edge with out_valid & out_ready: out_valid=0, go to IDLE. amp_out holds its last value.
- Rounding is exactly that of fixmul; no additional rounding is applied.
- Arithmetic wraps nowhere: ACC_W guarantees no overflow before the clamp.

Test Plan:
- Reset mid-MUL (assert reset_n=0 at k=7) -> out_valid=0 and in_ready=1 immediately; no output appears after release.
- U=[[0.5,0.5],[0.5,-0.5]] (131072, 131072, 131072, -131072; imag 0), a0=a1=0.5 real -> after 17 cycles, o0_re=131072, o0_im=0, o1_re=0, o1_im=0, sat=0.
- u00=(0, 131072), all other U entries 0, a0=(131072, 0), a1=0 -> o0=(0, 65536), o1=(0, 0), sat=0.
- u00=u01=262143 real, a0=a1=262143 real -> o0_re=262143, sat=1, o1=(0, 0).
- a0_re=-262144, u00=131072 real, all else 0 -> clamp applied; o0_re=-131071, sat=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid, with in_valid held high -> amp_out stable, in_ready=0, no second capture. Raising out_ready completes the transfer; the next capture occurs 1 cycle later.

Source files
------------

// File: rtl/fixmul.sv
// Signed fixed-point multiplier: sign bit plus IN_BITS-1 fraction bits on each operand.
// Result rounds half up, (a*b + 2^(IN_BITS-2)) >>> (IN_BITS-1).
// Operands must not be the most negative value; the caller clamps them away.
module fixmul #(
  parameter int unsigned IN_BITS  = 19,
  parameter int unsigned OUT_BITS = 19
) (
  input  logic [IN_BITS-1:0]  a,
  input  logic [IN_BITS-1:0]  b,
  output logic [OUT_BITS-1:0] p
);

  localparam logic signed [2*IN_BITS-1:0] Half =
    {{(IN_BITS+1){1'b0}}, 1'b1, {(IN_BITS-2){1'b0}}};

  logic signed [2*IN_BITS-1:0] a_ext;
  logic signed [2*IN_BITS-1:0] b_ext;
  logic signed [2*IN_BITS-1:0] full;
  logic signed [2*IN_BITS-1:0] rnd;
  logic                        unused_rnd;

  // Full-precision product, then round and drop the fraction LSBs.
  always_comb begin
    a_ext = {{IN_BITS{a[IN_BITS-1]}}, a};
    b_ext = {{IN_BITS{b[IN_BITS-1]}}, b};
    full  = a_ext * b_ext;
    rnd   = full + Half;
    p     = rnd[IN_BITS-1 +: OUT_BITS];
  end

  // Discarded fraction bits and the redundant top sign bit.
  assign unused_rnd = ^{rnd[IN_BITS-2:0], rnd[2*IN_BITS-1 -: (IN_BITS+1-OUT_BITS)]};

endmodule

// File: rtl/gate_pair_apply.sv
// Applies a 2x2 complex gate to one amplitude pair using a single shared fixmul.
// The 16 real products are issued one per cycle and accumulated, then saturated.
module gate_pair_apply #(
  parameter int unsigned W     = 19,
  parameter int unsigned ACC_W = W + 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*W-1:0] u_mat,
  input  logic [4*W-1:0] amp_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] amp_out,
  output logic           sat
);

  typedef enum logic [1:0] {StIdle, StMul, StSat, StDone} state_e;

  localparam logic [W-1:0] MaxPos  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MinSym  = {1'b1, {(W-2){1'b0}}, 1'b1};
  localparam logic [W-1:0] MostNeg = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] AccMax = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {{(ACC_W-W+1){1'b1}}, {(W-2){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [3:0]              k_q;
  logic [W-1:0]            u_re_q [4];
  logic [W-1:0]            u_im_q [4];
  logic [W-1:0]            a_re_q [2];
  logic [W-1:0]            a_im_q [2];
  // acc_q index matches output packing: 0=o0_re, 1=o0_im, 2=o1_re, 3=o1_im.
  logic signed [ACC_W-1:0] acc_q  [4];
  logic [4*W-1:0]          amp_out_q;
  logic                    sat_q;
  logic                    out_valid_q;

  logic [W-1:0]            mul_a, mul_b, prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic [1:0]              acc_idx;
  logic                    prod_sub;
  logic [W-1:0]            clamped [4];
  logic [3:0]              clamp_hit;

  // fixmul cannot take the most negative code, so it is pulled in by one LSB.
  function automatic logic [W-1:0] clamp_in(input logic [W-1:0] v);
    return (v == MostNeg) ? MinSym : v;
  endfunction

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign amp_out   = amp_out_q;
  assign sat       = sat_q;

  // Operand select: k[3]=row, k[2]=col, k[1:0]=term (re*re, -im*im, re*im, im*re).
  always_comb begin
    mul_a    = k_q[0] ? u_im_q[k_q[3:2]] : u_re_q[k_q[3:2]];
    mul_b    = (k_q[0] ^ k_q[1]) ? a_im_q[k_q[2]] : a_re_q[k_q[2]];
    prod_sub = (k_q[1:0] == 2'd1);
    acc_idx  = {k_q[3], k_q[1]};
  end

  fixmul #(
    .IN_BITS (W),
    .OUT_BITS(W)
  ) u_fixmul (
    .a(mul_a),
    .b(mul_b),
    .p(prod)
  );

  assign prod_ext = {{(ACC_W-W){prod[W-1]}}, prod};

  // Symmetric clamp of each accumulator to the W-bit output range.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      clamped[i]   = acc_q[i][W-1:0];
      clamp_hit[i] = 1'b0;
      if (acc_q[i] > AccMax) begin
        clamped[i]   = MaxPos;
        clamp_hit[i] = 1'b1;
      end else if (acc_q[i] < AccMin) begin
        clamped[i]   = MinSym;
        clamp_hit[i] = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: capture, 16 multiply cycles, one saturate cycle, hold until accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StMul;
      StMul:   if (k_q == 4'd15) state_d = StSat;
      StSat:   state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: operand capture, accumulation and the output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q         <= '0;
      amp_out_q   <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        u_re_q[i] <= '0;
        u_im_q[i] <= '0;
        acc_q[i]  <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        a_re_q[i] <= '0;
        a_im_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            k_q <= '0;
            for (int i = 0; i < 4; i++) begin
              u_re_q[i] <= clamp_in(u_mat[(2*i)*W +: W]);
              u_im_q[i] <= clamp_in(u_mat[(2*i+1)*W +: W]);
              acc_q[i]  <= '0;
            end
            for (int i = 0; i < 2; i++) begin
              a_re_q[i] <= clamp_in(amp_in[(2*i)*W +: W]);
              a_im_q[i] <= clamp_in(amp_in[(2*i+1)*W +: W]);
            end
          end
        end
        StMul: begin
          if (prod_sub) begin
            acc_q[acc_idx] <= acc_q[acc_idx] - prod_ext;
          end else begin
            acc_q[acc_idx] <= acc_q[acc_idx] + prod_ext;
          end
          k_q <= k_q + 4'd1;
        end
        StSat: begin
          amp_out_q   <= {clamped[3], clamped[2], clamped[1], clamped[0]};
          sat_q       <= |clamp_hit;
          out_valid_q <= 1'b1;
        end
        StDone: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_pair_apply.sv
// Directed bench for gate_pair_apply: vector table plus reset and backpressure sequences.
module tb_gate_pair_apply;

  localparam int W = 19;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [8*W-1:0] u_mat = '0;
  logic [4*W-1:0] amp_in = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [4*W-1:0] amp_out;
  logic           sat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gate_pair_apply #(
    .W    (W),
    .ACC_W(W + 2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .u_mat    (u_mat),
    .amp_in   (amp_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .amp_out  (amp_out),
    .sat      (sat)
  );

  typedef struct {
    string          name;
    logic [8*W-1:0] u;
    logic [4*W-1:0] a;
    logic [4*W-1:0] o;
    logic           s;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [8*W-1:0] pack_u(input int u00r, input int u00i, input int u01r,
                                            input int u01i, input int u10r, input int u10i,
                                            input int u11r, input int u11i);
    return {W'(u11i), W'(u11r), W'(u10i), W'(u10r), W'(u01i), W'(u01r), W'(u00i), W'(u00r)};
  endfunction

  function automatic logic [4*W-1:0] pack_a(input int r0, input int i0, input int r1,
                                            input int i1);
    return {W'(i1), W'(r1), W'(i0), W'(r0)};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Counts edges until out_valid rises, bounded so a dead DUT cannot hang the run.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic send(input logic [8*W-1:0] u, input logic [4*W-1:0] a);
    u_mat    = u;
    amp_in   = a;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int lat;
    send(vecs[i].u, vecs[i].a);
    check({vecs[i].name, "_busy"}, 128'(in_ready), 128'(0));
    wait_out(lat);
    check({vecs[i].name, "_latency"}, 128'(lat), 128'(17));
    check({vecs[i].name, "_amp"}, 128'(amp_out), 128'(vecs[i].o));
    check({vecs[i].name, "_sat"}, 128'(sat), 128'(vecs[i].s));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({vecs[i].name, "_accept"}, 128'({out_valid, in_ready}), 128'(2'b01));
    check({vecs[i].name, "_amp_hold"}, 128'(amp_out), 128'(vecs[i].o));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;

    vecs[0] = '{"hadamard", pack_u(131072, 0, 131072, 0, 131072, 0, -131072, 0),
                pack_a(131072, 0, 131072, 0), pack_a(131072, 0, 0, 0), 1'b0};
    vecs[1] = '{"imag_u", pack_u(0, 131072, 0, 0, 0, 0, 0, 0),
                pack_a(131072, 0, 0, 0), pack_a(0, 65536, 0, 0), 1'b0};
    vecs[2] = '{"pos_sat", pack_u(262143, 0, 262143, 0, 0, 0, 0, 0),
                pack_a(262143, 0, 262143, 0), pack_a(262143, 0, 0, 0), 1'b1};
    vecs[3] = '{"a_clamp", pack_u(131072, 0, 0, 0, 0, 0, 0, 0),
                pack_a(-262144, 0, 0, 0), pack_a(-131071, 0, 0, 0), 1'b0};
    vecs[4] = '{"complex", pack_u(131072, 131072, 0, 0, 0, 0, 0, -131072),
                pack_a(131072, -131072, 131072, 0), pack_a(131072, 0, 0, -65536), 1'b0};
    vecs[5] = '{"neg_sat_uclamp", pack_u(-262144, 0, -262143, 0, 0, 0, 0, 0),
                pack_a(262143, 0, 262143, 0), pack_a(-262143, 0, 0, 0), 1'b1};
    vecs[6] = '{"imag_sat_row1", pack_u(0, 0, 0, 0, 262143, 0, 262143, 0),
                pack_a(0, 262143, 0, 262143), pack_a(0, 0, 0, 262143), 1'b1};
    vecs[7] = '{"max_no_sat", pack_u(262143, 0, 0, 0, 0, 0, 0, 0),
                pack_a(262143, 0, 0, 0), pack_a(262142, 0, 0, 0), 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_amp_out", 128'(amp_out), 128'(0));
    check("rst_sat", 128'(sat), 128'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset while k=7: outputs clear at once and the transaction never completes.
    send(vecs[0].u, vecs[0].a);
    repeat (7) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_now", 128'({out_valid, in_ready, sat}), 128'(3'b010));
    check("midrst_amp", 128'(amp_out), 128'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("midrst_no_output", 128'(seen), 128'(0));
    check("midrst_idle", 128'(in_ready), 128'(1));

    // Backpressure with in_valid held high throughout.
    u_mat    = vecs[1].u;
    amp_in   = vecs[1].a;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    wait_out(lat);
    check("bp_latency", 128'(lat), 128'(17));
    u_mat  = vecs[0].u;
    amp_in = vecs[0].a;
    for (int c = 0; c < 10; c++) begin
      check("bp_hold", 128'({out_valid, in_ready, sat, amp_out}),
            128'({1'b1, 1'b0, vecs[1].s, vecs[1].o}));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_accept", 128'({out_valid, in_ready}), 128'(2'b01));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_capture", 128'(in_ready), 128'(0));
    wait_out(lat);
    check("bp_next_latency", 128'(lat), 128'(17));
    check("bp_next_amp", 128'(amp_out), 128'(vecs[0].o));
    check("bp_next_sat", 128'(sat), 128'(vecs[0].s));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_next_accept", 128'({out_valid, in_ready}), 128'(2'b01));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
